// File: rtl/snake_body_tracker.sv
// snake_body_tracker: variable-length store of snake segment positions
// (head at index 0) with stepped multi-cycle shift, direction control,
// growth and wall/self collision detection.
// Optional macro SNAKE_WRAP_EN: the head wraps around the screen edges
// instead of raising collide_wall (collide_wall then stays 0).
module snake_body_tracker #(
    parameter int unsigned XW       = 8,
    parameter int unsigned YW       = 7,
    parameter int unsigned MAX_LEN  = 16,
    parameter int unsigned INIT_LEN = 2,
    parameter int unsigned X0       = 39,
    parameter int unsigned Y0       = 59,
    parameter int unsigned STEP     = 10,
    parameter int unsigned XSCREEN  = 160,
    parameter int unsigned YSCREEN  = 120
) (
    input  logic                         clock_i,
    input  logic                         resetn_i,
    input  logic                         init_i,
    input  logic                         step_i,
    input  logic [1:0]                   dir_i,
    input  logic                         grow_i,
    input  logic [$clog2(MAX_LEN)-1:0]   rd_idx_i,
    output logic [XW-1:0]                rd_x_o,
    output logic [YW-1:0]                rd_y_o,
    output logic                         rd_valid_o,
    output logic [$clog2(MAX_LEN+1)-1:0] length_o,
    output logic [1:0]                   heading_o,
    output logic                         busy_o,
    output logic                         step_done_o,
    output logic                         collide_wall_o,
    output logic                         collide_self_o
);

    localparam int unsigned IW = $clog2(MAX_LEN);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    // Head arithmetic is one bit wider so a step past 0 shows up as negative.
    localparam logic [XW:0] STEP_X = (XW + 1)'(STEP);
    localparam logic [YW:0] STEP_Y = (YW + 1)'(STEP);
    localparam logic [XW:0] XMAX   = (XW + 1)'(XSCREEN - STEP);
    localparam logic [YW:0] YMAX   = (YW + 1)'(YSCREEN - STEP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CHECK,
        S_SHIFT,
        S_COMMIT,
        S_DEAD
    } state_e;

    state_e          state_q;
    logic [XW-1:0]   seg_x_q [MAX_LEN];
    logic [YW-1:0]   seg_y_q [MAX_LEN];
    logic [LW-1:0]   length_q;
    logic [1:0]      heading_q;
    logic [1:0]      dir_q;
    logic            grow_q;
    logic [XW-1:0]   new_x_q;
    logic [YW-1:0]   new_y_q;
    logic [IW-1:0]   idx_q;
    logic            hit_q;
    logic            busy_q;
    logic            step_done_q;
    logic            collide_wall_q;
    logic            collide_self_q;

    logic [XW:0]     cand_x;
    logic [YW:0]     cand_y;
    logic            neg_x, over_x, neg_y, over_y;
    logic [XW-1:0]   new_x_d;
    logic [YW-1:0]   new_y_d;
    logic            wall_hit_d;
    logic [IW-1:0]   tail_idx_d;
    logic [IW-1:0]   idx_prev_d;
    logic            tail_hit_d;
    logic            prev_hit_d;

    // Reset/init image of a segment: a horizontal line trailing left of the head.
    function automatic logic [XW-1:0] init_x(input int unsigned i);
        init_x = (i < INIT_LEN) ? XW'(X0 - i * STEP) : '0;
    endfunction

    function automatic logic [YW-1:0] init_y(input int unsigned i);
        init_y = (i < INIT_LEN) ? YW'(Y0) : '0;
    endfunction

    // Candidate new head from the current head and the effective direction.
    always_comb begin
        cand_x = {1'b0, seg_x_q[0]};
        cand_y = {1'b0, seg_y_q[0]};
        case (dir_q)
            2'd0:    cand_x = {1'b0, seg_x_q[0]} + STEP_X;
            2'd1:    cand_y = {1'b0, seg_y_q[0]} + STEP_Y;
            2'd2:    cand_y = {1'b0, seg_y_q[0]} - STEP_Y;
            default: cand_x = {1'b0, seg_x_q[0]} - STEP_X;
        endcase
        neg_x  = cand_x[XW];
        over_x = !cand_x[XW] && (cand_x > XMAX);
        neg_y  = cand_y[YW];
        over_y = !cand_y[YW] && (cand_y > YMAX);
`ifdef SNAKE_WRAP_EN
        new_x_d    = neg_x ? XMAX[XW-1:0] : (over_x ? '0 : cand_x[XW-1:0]);
        new_y_d    = neg_y ? YMAX[YW-1:0] : (over_y ? '0 : cand_y[YW-1:0]);
        wall_hit_d = 1'b0;
`else
        new_x_d    = cand_x[XW-1:0];
        new_y_d    = cand_y[YW-1:0];
        wall_hit_d = neg_x || over_x || neg_y || over_y;
`endif
    end

    // Tail and shift-source indices plus their comparisons against the new head.
    always_comb begin
        tail_idx_d = IW'(length_q - LW'(1));
        idx_prev_d = idx_q - IW'(1);
        tail_hit_d = (seg_x_q[tail_idx_d] == new_x_d) && (seg_y_q[tail_idx_d] == new_y_d);
        prev_hit_d = (seg_x_q[idx_prev_d] == new_x_q) && (seg_y_q[idx_prev_d] == new_y_q);
    end

    // Move sequencer and segment memory.
    always_ff @(posedge clock_i or negedge resetn_i) begin
        if (!resetn_i) begin
            state_q        <= S_IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            length_q       <= LW'(INIT_LEN);
            heading_q      <= 2'd0;
            dir_q          <= 2'd0;
            grow_q         <= 1'b0;
            new_x_q        <= '0;
            new_y_q        <= '0;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            busy_q         <= 1'b0;
            step_done_q    <= 1'b0;
            collide_wall_q <= 1'b0;
            collide_self_q <= 1'b0;
        end else if (init_i) begin
            state_q        <= S_IDLE;
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                seg_x_q[i] <= init_x(i);
                seg_y_q[i] <= init_y(i);
            end
            length_q       <= LW'(INIT_LEN);
            heading_q      <= 2'd0;
            dir_q          <= 2'd0;
            grow_q         <= 1'b0;
            idx_q          <= '0;
            hit_q          <= 1'b0;
            busy_q         <= 1'b0;
            step_done_q    <= 1'b0;
            collide_wall_q <= 1'b0;
            collide_self_q <= 1'b0;
        end else begin
            step_done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (step_i) begin
                        // A reversal onto the body is refused once there is a body.
                        if ((dir_i == ~heading_q) && (length_q > LW'(1))) begin
                            dir_q <= heading_q;
                        end else begin
                            dir_q <= dir_i;
                        end
                        grow_q  <= grow_i && (length_q < LW'(MAX_LEN));
                        hit_q   <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (wall_hit_d) begin
                        collide_wall_q <= 1'b1;
                        busy_q         <= 1'b0;
                        state_q        <= S_DEAD;
                    end else begin
                        new_x_q <= new_x_d;
                        new_y_q <= new_y_d;
                        // Growing keeps the old tail, so it becomes part of the body.
                        if (grow_q) begin
                            seg_x_q[IW'(length_q)] <= seg_x_q[tail_idx_d];
                            seg_y_q[IW'(length_q)] <= seg_y_q[tail_idx_d];
                            if (tail_hit_d) begin
                                hit_q <= 1'b1;
                            end
                        end
                        if (length_q > LW'(1)) begin
                            idx_q   <= tail_idx_d;
                            state_q <= S_SHIFT;
                        end else begin
                            state_q <= S_COMMIT;
                        end
                    end
                end
                S_SHIFT: begin
                    seg_x_q[idx_q] <= seg_x_q[idx_prev_d];
                    seg_y_q[idx_q] <= seg_y_q[idx_prev_d];
                    if (prev_hit_d) begin
                        hit_q <= 1'b1;
                    end
                    idx_q <= idx_prev_d;
                    if (idx_q == IW'(1)) begin
                        state_q <= S_COMMIT;
                    end
                end
                S_COMMIT: begin
                    seg_x_q[0]  <= new_x_q;
                    seg_y_q[0]  <= new_y_q;
                    heading_q   <= dir_q;
                    if (grow_q) begin
                        length_q <= length_q + LW'(1);
                    end
                    step_done_q <= 1'b1;
                    busy_q      <= 1'b0;
                    if (hit_q) begin
                        collide_self_q <= 1'b1;
                        state_q        <= S_DEAD;
                    end else begin
                        state_q        <= S_IDLE;
                    end
                end
                S_DEAD: begin
                    state_q <= S_DEAD;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Random-access read port, straight from the live array.
    always_comb begin
        rd_valid_o = LW'(rd_idx_i) < length_q;
        rd_x_o     = rd_valid_o ? seg_x_q[rd_idx_i] : '0;
        rd_y_o     = rd_valid_o ? seg_y_q[rd_idx_i] : '0;
    end

    assign length_o       = length_q;
    assign heading_o      = heading_q;
    assign busy_o         = busy_q;
    assign step_done_o    = step_done_q;
    assign collide_wall_o = collide_wall_q;
    assign collide_self_o = collide_self_q;

endmodule
